// File: rtl/mealy_ctrl_nch.sv
// N-channel two-output Mealy controller with a timed HOLD state per channel,
// a global freeze enable and optional registered B1/B2 outputs.
module mealy_ctrl_nch #(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 3,
  parameter bit REG_OUT     = 1'b0,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N_CH-1:0]     I,
  input  logic [N_CH-1:0]     S,
  output logic [N_CH-1:0]     B1,
  output logic [N_CH-1:0]     B2,
  output logic [2*N_CH-1:0]   y,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    HOLD   = 2'b10,
    BAD    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [N_CH-1:0] busy_vec;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             b1_m, b2_m;
    logic             b1_out, b2_out;
    logic             go;

    assign go = I[gi] & ~S[gi];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      b1_m    = 1'b0;
      b2_m    = 1'b0;
      case (state_q)
        IDLE: begin
          b1_m = go;
          if (en && go) state_d = ACTIVE;
        end
        ACTIVE: begin
          b1_m = go;
          b2_m = S[gi];
          // Sensor wins over request: a hit always starts a full hold period.
          if (en) begin
            if (S[gi]) begin
              state_d = HOLD;
              cnt_d   = CNT_LOAD;
            end else if (!I[gi]) begin
              state_d = IDLE;
            end
          end
        end
        HOLD: begin
          b2_m = 1'b1;
          if (en) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else state_d = go ? ACTIVE : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (!en) begin
        b1_m = 1'b0;
        b2_m = 1'b0;
      end
    end

    if (REG_OUT) begin : g_reg
      logic b1_q, b2_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          b1_q <= 1'b0;
          b2_q <= 1'b0;
        end else begin
          b1_q <= b1_m;
          b2_q <= b2_m;
        end
      end
      assign b1_out = b1_q;
      assign b2_out = b2_q;
    end else begin : g_comb
      assign b1_out = b1_m;
      assign b2_out = b2_m;
    end

    // Outputs are forced low for the whole reset assertion, in either mode.
    assign B1[gi]         = rst_n & b1_out;
    assign B2[gi]         = rst_n & b2_out;
    assign y[2*gi +: 2]   = state_q;
    assign busy_vec[gi]   = (state_q != IDLE);
  end

  assign busy = |busy_vec;

endmodule

// File: tb/tb_mealy_ctrl_nch.sv
// Directed bench: combinational, registered and HOLD_CYCLES=1 instances share
// the same stimulus; each task checks hand-computed values inline.
module tb_mealy_ctrl_nch;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [3:0] I, S;
  logic [3:0] b1_a, b2_a, b1_r, b2_r, b1_h, b2_h;
  logic [7:0] y_a, y_r, y_h;
  logic       busy_a, busy_r, busy_h;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mealy_ctrl_nch #(.N_CH(4), .HOLD_CYCLES(3), .REG_OUT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .I(I), .S(S),
    .B1(b1_a), .B2(b2_a), .y(y_a), .busy(busy_a));

  mealy_ctrl_nch #(.N_CH(4), .HOLD_CYCLES(3), .REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .en(en), .I(I), .S(S),
    .B1(b1_r), .B2(b2_r), .y(y_r), .busy(busy_r));

  mealy_ctrl_nch #(.N_CH(4), .HOLD_CYCLES(1), .REG_OUT(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .I(I), .S(S),
    .B1(b1_h), .B2(b2_h), .y(y_h), .busy(busy_h));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; I = 4'hF; S = 4'h0;
    tick(); tick();
    vectors++; if ({b1_a, b2_a} !== 8'h00) begin miscompares++; $display("FAIL reset_b_comb got %h want 00", {b1_a, b2_a}); end
    vectors++; if ({b1_r, b2_r} !== 8'h00) begin miscompares++; $display("FAIL reset_b_reg got %h want 00", {b1_r, b2_r}); end
    vectors++; if (y_a !== 8'h00) begin miscompares++; $display("FAIL reset_y got %h want 00", y_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_a); end
    rst_n = 1'b1; en = 1'b0; #1;
    vectors++; if ({b1_a, b2_a} !== 8'h00) begin miscompares++; $display("FAIL release_en0_b got %h want 00", {b1_a, b2_a}); end
    tick();
    vectors++; if (y_a !== 8'h00) begin miscompares++; $display("FAIL release_en0_y got %h want 00", y_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL release_en0_busy got %b want 0", busy_a); end
    I = 4'h0; en = 1'b1;
    tick();
    vectors++; if (y_a !== 8'h00) begin miscompares++; $display("FAIL release_idle_y got %h want 00", y_a); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    I = 4'h1; S = 4'h0; #1;
    vectors++; if ({b1_a, b2_a} !== 8'h10) begin miscompares++; $display("FAIL basic_req_b_comb got %h want 10", {b1_a, b2_a}); end
    vectors++; if ({b1_r, b2_r} !== 8'h00) begin miscompares++; $display("FAIL basic_req_b_reg got %h want 00", {b1_r, b2_r}); end
    tick();
    vectors++; if (y_a !== 8'h01) begin miscompares++; $display("FAIL basic_active_y got %h want 01", y_a); end
    vectors++; if (y_r !== 8'h01) begin miscompares++; $display("FAIL basic_active_y_reg got %h want 01", y_r); end
    vectors++; if ({b1_r, b2_r} !== 8'h10) begin miscompares++; $display("FAIL basic_active_b_reg got %h want 10", {b1_r, b2_r}); end
    S = 4'h1; #1;
    vectors++; if ({b1_a, b2_a} !== 8'h01) begin miscompares++; $display("FAIL basic_sense_b_comb got %h want 01", {b1_a, b2_a}); end
    vectors++; if ({b1_r, b2_r} !== 8'h10) begin miscompares++; $display("FAIL basic_sense_b_reg got %h want 10", {b1_r, b2_r}); end
    tick();
    vectors++; if (y_a !== 8'h02) begin miscompares++; $display("FAIL basic_hold1_y got %h want 02", y_a); end
    vectors++; if (y_r !== 8'h02) begin miscompares++; $display("FAIL basic_hold1_y_reg got %h want 02", y_r); end
    vectors++; if (y_h !== 8'h02) begin miscompares++; $display("FAIL h1_hold_y got %h want 02", y_h); end
    vectors++; if ({b1_r, b2_r} !== 8'h01) begin miscompares++; $display("FAIL basic_hold1_b_reg got %h want 01", {b1_r, b2_r}); end
    S = 4'h0; #1;
    vectors++; if ({b1_a, b2_a} !== 8'h01) begin miscompares++; $display("FAIL basic_hold1_b_comb got %h want 01", {b1_a, b2_a}); end
    tick();
    vectors++; if (y_a !== 8'h02) begin miscompares++; $display("FAIL basic_hold2_y got %h want 02", y_a); end
    vectors++; if (y_h !== 8'h01) begin miscompares++; $display("FAIL h1_exit_y got %h want 01", y_h); end
    tick();
    vectors++; if (y_a !== 8'h02) begin miscompares++; $display("FAIL basic_hold3_y got %h want 02", y_a); end
    vectors++; if (b2_a !== 4'h1) begin miscompares++; $display("FAIL basic_hold3_b2 got %h want 1", b2_a); end
    tick();
    vectors++; if (y_a !== 8'h01) begin miscompares++; $display("FAIL basic_exit_active_y got %h want 01", y_a); end
    vectors++; if ({b1_a, b2_a} !== 8'h10) begin miscompares++; $display("FAIL basic_exit_b_comb got %h want 10", {b1_a, b2_a}); end
    vectors++; if ({b1_r, b2_r} !== 8'h01) begin miscompares++; $display("FAIL basic_exit_b_reg got %h want 01", {b1_r, b2_r}); end
    tick();
    vectors++; if ({b1_r, b2_r} !== 8'h10) begin miscompares++; $display("FAIL basic_exit_b_reg_late got %h want 10", {b1_r, b2_r}); end
    S = 4'h1;
    tick();
    I = 4'h0; S = 4'h0;
    tick(); tick();
    vectors++; if (y_a !== 8'h02 || busy_a !== 1'b1) begin miscompares++; $display("FAIL basic_hold_to_idle_pre got y=%h busy=%b want y=02 busy=1", y_a, busy_a); end
    tick();
    vectors++; if (y_a !== 8'h00 || busy_a !== 1'b0) begin miscompares++; $display("FAIL basic_hold_to_idle got y=%h busy=%b want y=00 busy=0", y_a, busy_a); end
    $display("test_basic done");
  endtask

  task automatic test_enable_freeze();
    I = 4'h1; S = 4'h0;
    tick();
    S = 4'h1;
    tick();
    en = 1'b0; S = 4'h0; #1;
    vectors++; if ({b1_a, b2_a} !== 8'h00) begin miscompares++; $display("FAIL freeze_b_comb got %h want 00", {b1_a, b2_a}); end
    vectors++; if (y_a !== 8'h02) begin miscompares++; $display("FAIL freeze_entry_y got %h want 02", y_a); end
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++; if (y_a !== 8'h02 || busy_a !== 1'b1) begin miscompares++; $display("FAIL freeze_y_%0d got y=%h busy=%b want y=02 busy=1", k, y_a, busy_a); end
      vectors++; if ({b1_a, b2_a, b1_r, b2_r} !== 16'h0000) begin miscompares++; $display("FAIL freeze_b_%0d got %h want 0000", k, {b1_a, b2_a, b1_r, b2_r}); end
    end
    en = 1'b1; #1;
    vectors++; if (b2_a !== 4'h1) begin miscompares++; $display("FAIL freeze_resume_b2 got %h want 1", b2_a); end
    tick();
    vectors++; if (y_a !== 8'h02) begin miscompares++; $display("FAIL freeze_resume1_y got %h want 02", y_a); end
    tick();
    vectors++; if (y_a !== 8'h02) begin miscompares++; $display("FAIL freeze_resume2_y got %h want 02", y_a); end
    tick();
    vectors++; if (y_a !== 8'h01) begin miscompares++; $display("FAIL freeze_resume_exit_y got %h want 01", y_a); end
    I = 4'h0;
    tick();
    vectors++; if (y_a !== 8'h00) begin miscompares++; $display("FAIL freeze_idle_y got %h want 00", y_a); end
    $display("test_enable_freeze done");
  endtask

  task automatic test_mid_hold_reset();
    I = 4'h1; S = 4'h0;
    tick();
    S = 4'h1;
    tick();
    S = 4'h0;
    tick();
    vectors++; if (y_a !== 8'h02) begin miscompares++; $display("FAIL midrst_hold2_y got %h want 02", y_a); end
    rst_n = 1'b0; #1;
    vectors++; if ({b1_a, b2_a} !== 8'h00) begin miscompares++; $display("FAIL midrst_b_comb got %h want 00", {b1_a, b2_a}); end
    vectors++; if ({b1_r, b2_r} !== 8'h00) begin miscompares++; $display("FAIL midrst_b_reg got %h want 00", {b1_r, b2_r}); end
    tick();
    vectors++; if (y_a !== 8'h00 || busy_a !== 1'b0) begin miscompares++; $display("FAIL midrst_state got y=%h busy=%b want y=00 busy=0", y_a, busy_a); end
    vectors++; if (y_r !== 8'h00) begin miscompares++; $display("FAIL midrst_y_reg got %h want 00", y_r); end
    rst_n = 1'b1; I = 4'h0;
    tick();
    vectors++; if (y_a !== 8'h00) begin miscompares++; $display("FAIL midrst_after_y got %h want 00", y_a); end
    $display("test_mid_hold_reset done");
  endtask

  task automatic test_multi_channel();
    I = 4'b1010; S = 4'b0010; #1;
    vectors++; if (b1_a !== 4'b1000) begin miscompares++; $display("FAIL multi_b1 got %b want 1000", b1_a); end
    vectors++; if (b2_a !== 4'b0000) begin miscompares++; $display("FAIL multi_b2 got %b want 0000", b2_a); end
    tick();
    vectors++; if (y_a !== 8'b01_00_00_00 || busy_a !== 1'b1) begin miscompares++; $display("FAIL multi_y got y=%b busy=%b want y=01000000 busy=1", y_a, busy_a); end
    S = 4'b1000; #1;
    vectors++; if ({b1_a, b2_a} !== 8'b0010_1000) begin miscompares++; $display("FAIL multi_sense_b got %b want 00101000", {b1_a, b2_a}); end
    tick();
    vectors++; if (y_a !== 8'b10_00_01_00) begin miscompares++; $display("FAIL multi_hold_y got %b want 10000100", y_a); end
    vectors++; if ({b1_a, b2_a} !== 8'b0010_1000) begin miscompares++; $display("FAIL multi_hold_b got %b want 00101000", {b1_a, b2_a}); end
    I = 4'h0; S = 4'h0;
    tick();
    vectors++; if (y_a !== 8'b10_00_00_00) begin miscompares++; $display("FAIL multi_ch1_idle_y got %b want 10000000", y_a); end
    tick(); tick();
    vectors++; if (y_a !== 8'h00 || busy_a !== 1'b0) begin miscompares++; $display("FAIL multi_all_idle got y=%b busy=%b want y=00000000 busy=0", y_a, busy_a); end
    $display("test_multi_channel done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable_freeze();
    test_mid_hold_reset();
    test_multi_channel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mealy_ctrl_nch.md
Name: mealy_ctrl_nch

Overview:
- Parametrised successor of the single-channel two-output Mealy controller (inputs I, S; outputs B1, B2).
- Instantiates N_CH independent channels that share one clock and a global enable.
- Adds a timed HOLD state per channel.
- Adds an optional registered-output mode for timing closure.
- Sits between the debounced request/sensor inputs and the actuator drivers.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- HOLD_CYCLES, 3, number of cycles a channel stays in HOLD (must be ≥1).
- REG_OUT, 0: 0 = B1/B2 are combinational Mealy outputs; 1 = B1/B2 are registered (+1 cycle latency).
- CNT_W, $clog2(HOLD_CYCLES+1), width of each hold counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  global enable; 0 freezes all channel state.
- I  in  N_CH  per-channel request.
- S  in  N_CH  per-channel sensor.
- B1  out  N_CH  per-channel drive output 1.
- B2  out  N_CH  per-channel drive output 2.
- y  out  2*N_CH  per-channel state code, channel k at bits [2k+1:2k].
- busy  out  1  OR over channels of (state != IDLE).

Behaviour:
- Reset (sampled on clk rising edge with rst_n=0):
  - All channels go to IDLE (code 00), counters to 0, output registers (REG_OUT=1) to 0.
  - While rst_n=0, B1=B2=0 in both modes.
  - After reset, y=0 and busy=0.
  - Reset mid-HOLD aborts the count; the channel is IDLE on the next cycle.
- State codes: IDLE=00, ACTIVE=01, HOLD=10; 11 is illegal and recovers to IDLE next cycle with B1=B2=0.
- Per-channel Mealy outputs (Ik, Sk are current inputs):
  - IDLE: B1 = Ik & ~Sk; B2 = 0.
  - ACTIVE: B1 = Ik & ~Sk; B2 = Sk.
  - HOLD: B1 = 0; B2 = 1.
- Per-channel transitions, evaluated only when en=1:
  - IDLE → ACTIVE if Ik & ~Sk; otherwise stay in IDLE.
  - ACTIVE → HOLD if Sk, loading counter = HOLD_CYCLES-1. Sk has priority over Ik.
  - ACTIVE → IDLE if ~Ik & ~Sk; otherwise stay in ACTIVE.
  - HOLD, counter ≠ 0: decrement and stay; inputs are ignored.
  - HOLD, counter = 0: → ACTIVE if Ik & ~Sk, else → IDLE.
  - Net effect: HOLD lasts exactly HOLD_CYCLES cycles.
- en=0:
  - State and counters hold their values.
  - B1=B2=0 regardless of state.
  - y and busy still reflect the held state.
  - en re-asserted mid-HOLD resumes the count from the held value.
- REG_OUT=0: B1/B2 follow input changes in the same cycle (zero latency, Mealy).
- REG_OUT=1:
  - B1/B2 are the Mealy values registered at the clock edge, i.e. one cycle late.
  - y and busy are unaffected by REG_OUT.
- Channels are fully independent.
  - Simultaneous events on different channels are handled in the same cycle.
  - There is no arbitration between channels.
- HOLD_CYCLES=1: HOLD lasts one cycle; the counter is loaded with 0.

Test Plan:
- Reset: rst_n=0 for 2 cycles with I=4'hF, S=0 → B1=B2=0, y=0, busy=0. Release → y stays 0 until the first edge with en=1.
- Basic path, channel 0, REG_OUT=0, HOLD_CYCLES=3, en=1:
  - I0=1, S0=0 → B1[0]=1 immediately; y[1:0]=01 after the edge.
  - S0=1 → B2[0]=1, B1[0]=0 same cycle; y[1:0]=10 after the edge.
  - B2[0] stays 1 for exactly 3 cycles, then y[1:0]=01 if I0=1 else 00.
- Enable freeze: enter HOLD, drop en for 5 cycles → y[1:0] stays 10, B1=B2=0. Restore en → 3 HOLD cycles counted in total across the gap.
- Mid-HOLD reset: rst_n=0 on the 2nd HOLD cycle → next cycle y=0, B1=B2=0, busy=0.
- Multi-channel: I=4'b1010, S=4'b0010 in IDLE →
  - Same cycle: B1=4'b1000 (ch1 blocked by its sensor).
  - After one edge: y=8'b01_00_00_00, busy=1.
  - Then S=4'b1000 → ch3 enters HOLD while ch1 is unaffected.
- REG_OUT=1: repeat the basic path → every B1/B2 transition appears exactly one cycle later than with REG_OUT=0; y timing is identical.
